// File: rtl/ram_loader.sv
// Byte-stream to 16-bit RAM word loader: two bytes per word, high byte first.
// Optional running word checksum enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [15:0]       ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic [15:0]       checksum
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [7:0]        hi_byte;
    logic [7:0]        lo_byte;
    logic [ADDR_W:0]   count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            hi_byte   <= '0;
            lo_byte   <= '0;
            count     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= word_count;
                        count     <= '0;
                        state     <= (word_count == '0) ? DONE : HI;
                    end
                end
                HI: begin
                    if (byte_valid) begin
                        hi_byte <= byte_data;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (byte_valid) begin
                        lo_byte <= byte_data;
                        state   <= WR;
                    end
                end
                WR: begin
                    // address wraps naturally at 2^ADDR_W
                    addr      <= addr + ADDR_W'(1);
                    count     <= count + (ADDR_W + 1)'(1);
                    remaining <= remaining - (ADDR_W + 1)'(1);
                    state     <= (remaining == (ADDR_W + 1)'(1)) ? DONE : HI;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (state == IDLE && start) begin
            sum <= '0;
        end else if (state == WR) begin
            sum <= sum + {hi_byte, lo_byte};
        end
    end

    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif

    assign byte_ready    = (state == HI) || (state == LO);
    assign ram_load      = (state == WR);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign ram_in        = {hi_byte, lo_byte};
    assign ram_address   = addr;
    assign words_written = count;

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter ADDR_W, default 14, RAM word-address width (matches the 16K x 16 data RAM).
REQ-002 clk  input  1  rising-edge clock shared with the downstream RAM.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  pulse; begins a load session when idle.
REQ-005 start_addr  input  ADDR_W  first RAM address written in the session.
REQ-006 word_count  input  ADDR_W+1  number of 16-bit words to load (0..16384).
REQ-007 byte_data  input  8  incoming byte stream.
REQ-008 byte_valid  input  1  byte_data holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts byte this cycle; transfer occurs when byte_valid&byte_ready.
REQ-010 ram_in  output  16  write data to RAM "in" port.
REQ-011 ram_load  output  1  write strobe to RAM "load" port.
REQ-012 ram_address  output  ADDR_W  RAM address port.
REQ-013 busy  output  1  session in progress (state not IDLE).
REQ-014 done  output  1  one-cycle pulse at session end.
REQ-015 words_written  output  ADDR_W+1  words written in current/last session.
REQ-016 checksum  output  16  running word checksum (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, HI, LO, WR, DONE; all outputs registered or decoded from state/registers, no combinational path from byte_valid to ram_load.
REQ-018 IDLE: byte_ready=0, ram_load=0, busy=0; start=1 latches start_addr and word_count, clears words_written (and checksum), goes to DONE if word_count==0 else HI.
REQ-019 start outside IDLE SHALL be ignored; start_addr/word_count changes after latching SHALL have no effect.
REQ-020 HI: byte_ready=1; on transfer, byte stored as word bits [15:8], go LO; otherwise stay HI.
REQ-021 LO: byte_ready=1; on transfer, byte stored as bits [7:0], go WR; otherwise stay LO.
REQ-022 WR: byte_ready=0, ram_load=1 for exactly one cycle, ram_in={hi,lo}, ram_address=current address.
REQ-023 On leaving WR: address increments by 1 modulo 2^ADDR_W (16383 wraps to 0), words_written increments, remaining count decrements; go DONE if remaining reaches 0, else HI.
REQ-024 DONE: done=1 for one cycle, busy=1, then IDLE; words_written holds its final value until next start.
REQ-025 Throughput SHALL be one word per 3 cycles with byte_valid held high; RAM write occurs the cycle after the low byte transfer.
REQ-026 ram_load SHALL be 0 in every state except WR; ram_address SHALL show the current address in all states.

Reset
REQ-027 reset SHALL force state IDLE and clear address, remaining count, hi/lo registers, words_written and checksum to 0; ram_load, byte_ready, busy, done = 0 after the edge.
REQ-028 reset mid-session (any state, including WR) SHALL abort with no further RAM write after the reset edge; reset takes priority over start in the same cycle.

Configuration
REQ-029 Macro RAM_LOADER_CHECKSUM_EN defined: checksum = 16-bit sum (mod 2^16) of all words written this session, cleared on accepted start, updated on leaving WR.
REQ-030 Macro RAM_LOADER_CHECKSUM_EN undefined: checksum port SHALL be constant 0 and no accumulator logic SHALL exist; all other behaviour identical.

Verification
REQ-031 start_addr=0x0010, word_count=2, bytes 12 34 AB CD, valid always 1 -> writes 0x1234@0x0010, 0xABCD@0x0011, done pulse on 7th cycle after start, words_written=2.
REQ-032 start_addr=0x3FFF, word_count=2, bytes 00 01 00 02 -> 0x0001@0x3FFF, 0x0002@0x0000 (wrap).
REQ-033 word_count=0 with start -> no ram_load, done pulses one cycle after start, words_written=0.
REQ-034 byte_valid toggled 1-0-1 each cycle, word_count=1, bytes 55 AA -> single write 0x55AA, byte_ready never drops in HI/LO, no byte lost or duplicated.
REQ-035 reset asserted in LO after high byte accepted, then start word_count=1, bytes 00 07 -> no write before reset, after restart exactly one write 0x0007.
REQ-036 With RAM_LOADER_CHECKSUM_EN: words 0xFFFF, 0x0002 -> checksum=0x0001; without macro -> checksum=0x0000 throughout.
